// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared definitions for the CPU peripheral bus arbiter:
// FSM state encodings, counter width and requester indices.
package cpu_bus_arbiter_pkg;

  // Sequencer state encodings. These are plain constants rather than an enum
  // so they match the legacy encodings used elsewhere in the codebase.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Width of the strobe and timeout counters. It covers TIMEOUT up to 65535.
  localparam int TMO_W = 16;

  // Requester indices.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/bus_rr_arbiter.sv
// Two-way round-robin grant logic (purely combinational).
// On a tie, the requester that did not win last time is granted.
module bus_rr_arbiter
  import cpu_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  // Pick the winner. A lone request always wins; a tie goes to the other index.
  always_comb begin
    grant_valid = |req;
    grant_idx   = REQ_CPU;
    if (req == 2'b11) begin
      grant_idx = ~last_grant;
    end else if (req[1]) begin
      grant_idx = REQ_DMA;
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares the external peripheral bus between the CPU core (requester 0)
// and the DMA/debug master (requester 1). It latches the winning transaction
// and runs the strobe protocol. It waits for ready, or times out, and then
// returns ack, err and read data.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int          DATA_W        = 32,
  parameter int          ADDR_W        = 32,
  parameter int          STROBE_CYCLES = 1,
  parameter int          TIMEOUT       = 255,
  parameter logic [31:0] RESET_ADDR    = 32'h0
) (
  input  logic              i_cpu_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic              o_err0,
  output logic              o_err1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic              o_grant,
  output logic              o_bus_clk,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_data,
  input  logic [DATA_W-1:0] i_bus_data,
  input  logic              i_bus_data_ready
);

  localparam logic [TMO_W-1:0]  STROBE_LAST = TMO_W'(STROBE_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT   = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0]  CNT_ONE     = TMO_W'(1);
  localparam logic [ADDR_W-1:0] IDLE_ADDR   = ADDR_W'(RESET_ADDR);

  logic [2:0]        state_reg;
  logic              last_grant_reg;
  logic              grant_reg;
  logic              busy_reg;
  logic              bus_clk_reg;
  logic              bus_we_reg;
  logic [ADDR_W-1:0] bus_addr_reg;
  logic [DATA_W-1:0] bus_data_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [1:0]        ack_reg;
  logic [1:0]        err_reg;
  logic [TMO_W-1:0]  strobe_cnt_reg;
  logic [TMO_W-1:0]  wait_cnt_reg;

  logic              grant_valid;
  logic              grant_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [TMO_W-1:0]  wait_cnt_next;

  bus_rr_arbiter u_rr (
    .req         ({i_req1, i_req0}),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Mux the winning requester's transaction and form the next timeout count.
  always_comb begin
    sel_we        = grant_idx ? i_we1    : i_we0;
    sel_addr      = grant_idx ? i_addr1  : i_addr0;
    sel_wdata     = grant_idx ? i_wdata1 : i_wdata0;
    wait_cnt_next = wait_cnt_reg + CNT_ONE;
  end

  // Sequencer. Bus outputs are registered and double as the latched copy of
  // the granted transaction, so requester inputs may change after the grant.
  always_ff @(posedge i_cpu_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= REQ_DMA;
      grant_reg      <= REQ_CPU;
      busy_reg       <= 1'b0;
      bus_clk_reg    <= 1'b0;
      bus_we_reg     <= 1'b0;
      bus_addr_reg   <= IDLE_ADDR;
      bus_data_reg   <= '0;
      rdata_reg      <= '0;
      ack_reg        <= 2'b00;
      err_reg        <= 2'b00;
      strobe_cnt_reg <= '0;
      wait_cnt_reg   <= '0;
    end else begin
      ack_reg <= 2'b00;
      err_reg <= 2'b00;
      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            grant_reg      <= grant_idx;
            last_grant_reg <= grant_idx;
            busy_reg       <= 1'b1;
            bus_we_reg     <= sel_we;
            bus_addr_reg   <= sel_addr;
            bus_data_reg   <= sel_we ? sel_wdata : '0;
            state_reg      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          bus_clk_reg    <= 1'b1;
          strobe_cnt_reg <= '0;
          state_reg      <= ST_STROBE;
        end
        ST_STROBE: begin
          if (strobe_cnt_reg == STROBE_LAST) begin
            wait_cnt_reg <= '0;
            state_reg    <= ST_WAIT;
          end else begin
            strobe_cnt_reg <= strobe_cnt_reg + CNT_ONE;
          end
        end
        ST_WAIT: begin
          if (i_bus_data_ready) begin
            if (!bus_we_reg) begin
              rdata_reg <= i_bus_data;
            end
            ack_reg[grant_reg] <= 1'b1;
            bus_clk_reg        <= 1'b0;
            bus_we_reg         <= 1'b0;
            state_reg          <= ST_DONE;
          end else if (wait_cnt_next == TMO_LIMIT) begin
            if (!bus_we_reg) begin
              rdata_reg <= '0;
            end
            ack_reg[grant_reg] <= 1'b1;
            err_reg[grant_reg] <= 1'b1;
            bus_clk_reg        <= 1'b0;
            bus_we_reg         <= 1'b0;
            state_reg          <= ST_DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_next;
          end
        end
        ST_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy_reg    <= 1'b0;
          bus_clk_reg <= 1'b0;
          bus_we_reg  <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ack0     = ack_reg[0];
  assign o_ack1     = ack_reg[1];
  assign o_err0     = err_reg[0];
  assign o_err1     = err_reg[1];
  assign o_rdata    = rdata_reg;
  assign o_busy     = busy_reg;
  assign o_grant    = grant_reg;
  assign o_bus_clk  = bus_clk_reg;
  assign o_bus_we   = bus_we_reg;
  assign o_bus_addr = bus_addr_reg;
  assign o_bus_data = bus_data_reg;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed self-checking bench for cpu_bus_arbiter (default parameters).
module tb_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata;
  logic        busy, grant;
  logic        bus_clk, bus_we;
  logic [31:0] bus_addr, bus_data, bus_rdata;
  logic        ready;

  int checks = 0;
  int errors = 0;
  int acks_seen;
  int waited;
  logic        got_ack;
  logic        exp_idx;

  always #5 clk = ~clk;

  cpu_bus_arbiter dut (
    .i_cpu_clk        (clk),
    .i_rst            (rst),
    .i_req0           (req0),
    .i_req1           (req1),
    .i_we0            (we0),
    .i_we1            (we1),
    .i_addr0          (addr0),
    .i_addr1          (addr1),
    .i_wdata0         (wdata0),
    .i_wdata1         (wdata1),
    .o_ack0           (ack0),
    .o_ack1           (ack1),
    .o_err0           (err0),
    .o_err1           (err1),
    .o_rdata          (rdata),
    .o_busy           (busy),
    .o_grant          (grant),
    .o_bus_clk        (bus_clk),
    .o_bus_we         (bus_we),
    .o_bus_addr       (bus_addr),
    .o_bus_data       (bus_data),
    .i_bus_data       (bus_rdata),
    .i_bus_data_ready (ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    bus_rdata = '0; ready = 1'b0;
    tick(); tick();
    chk("rst_ack0", {31'd0, ack0}, 32'd0);
    chk("rst_ack1", {31'd0, ack1}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bus_clk", {31'd0, bus_clk}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_grant", {31'd0, grant}, 32'd0);
    rst = 1'b0;
    tick();

    // CPU read, ready already high: ack four cycles after the request.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_9000;
    bus_rdata = 32'hDEAD_BEEF; ready = 1'b1;
    tick();
    chk("t1_setup_clk", {31'd0, bus_clk}, 32'd0);
    chk("t1_setup_busy", {31'd0, busy}, 32'd1);
    chk("t1_setup_addr", bus_addr, 32'h0000_9000);
    chk("t1_setup_we", {31'd0, bus_we}, 32'd0);
    chk("t1_setup_grant", {31'd0, grant}, 32'd0);
    tick();
    chk("t1_strobe_clk", {31'd0, bus_clk}, 32'd1);
    tick();
    chk("t1_wait_clk", {31'd0, bus_clk}, 32'd1);
    chk("t1_wait_ack0", {31'd0, ack0}, 32'd0);
    tick();
    chk("t1_done_ack0", {31'd0, ack0}, 32'd1);
    chk("t1_done_err0", {31'd0, err0}, 32'd0);
    chk("t1_done_ack1", {31'd0, ack1}, 32'd0);
    chk("t1_done_rdata", rdata, 32'hDEAD_BEEF);
    chk("t1_done_clk", {31'd0, bus_clk}, 32'd0);
    $display("txn cpu read  addr=%h rdata=%h err=%0d", 32'h0000_9000, rdata, err0);
    req0 = 1'b0;
    tick();
    chk("t1_idle_ack0", {31'd0, ack0}, 32'd0);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // DMA write, ready rises in the 6th WAIT cycle.
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_9004; wdata1 = 32'h1234_5678;
    bus_rdata = 32'hBAD0_0000; ready = 1'b0;
    tick();
    chk("t2_setup_we", {31'd0, bus_we}, 32'd1);
    chk("t2_setup_data", bus_data, 32'h1234_5678);
    chk("t2_setup_addr", bus_addr, 32'h0000_9004);
    chk("t2_setup_grant", {31'd0, grant}, 32'd1);
    wdata1 = 32'hFFFF_0000;
    addr1 = 32'h0000_0000;
    tick();
    chk("t2_strobe_data", bus_data, 32'h1234_5678);
    chk("t2_strobe_clk", {31'd0, bus_clk}, 32'd1);
    tick();
    acks_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (ack0 || ack1) acks_seen++;
      tick();
    end
    chk("t2_early_acks", acks_seen, 0);
    chk("t2_wait_we", {31'd0, bus_we}, 32'd1);
    chk("t2_wait_data", bus_data, 32'h1234_5678);
    chk("t2_wait_addr", bus_addr, 32'h0000_9004);
    ready = 1'b1;
    tick();
    chk("t2_done_ack1", {31'd0, ack1}, 32'd1);
    chk("t2_done_err1", {31'd0, err1}, 32'd0);
    chk("t2_done_ack0", {31'd0, ack0}, 32'd0);
    chk("t2_done_rdata", rdata, 32'hDEAD_BEEF);
    chk("t2_done_we", {31'd0, bus_we}, 32'd0);
    chk("t2_done_data_hold", bus_data, 32'h1234_5678);
    $display("txn dma write addr=%h wdata=%h err=%0d", 32'h0000_9004, 32'h1234_5678, err1);
    req1 = 1'b0; we1 = 1'b0;
    tick();

    // Both requests held from reset: grants alternate 0,1,0,1.
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h0000_9100; addr1 = 32'h0000_9200;
    bus_rdata = 32'h5555_0000; ready = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      exp_idx = t[0];
      got_ack = 1'b0;
      waited = 0;
      while (!got_ack && waited < 12) begin
        tick();
        waited++;
        chk("t3_no_overlap", {31'd0, ack0 & ack1}, 32'd0);
        if (ack0 || ack1) got_ack = 1'b1;
      end
      chk("t3_ack_seen", {31'd0, got_ack}, 32'd1);
      chk("t3_ack_index", {31'd0, ack1}, {31'd0, exp_idx});
      chk("t3_grant", {31'd0, grant}, {31'd0, exp_idx});
      $display("txn fair #%0d grant=%0d ack0=%0d ack1=%0d", t, grant, ack0, ack1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Reset pulsed during WAIT of a CPU read aborts with no ack.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_9008;
    bus_rdata = 32'h7777_7777; ready = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t5_wait_clk", {31'd0, bus_clk}, 32'd1);
    req0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_clk", {31'd0, bus_clk}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_addr", bus_addr, 32'h0);
    chk("t5_rst_rdata", rdata, 32'h0);
    chk("t5_rst_ack0", {31'd0, ack0}, 32'd0);
    tick();
    chk("t5_rst_hold_ack0", {31'd0, ack0}, 32'd0);
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    bus_rdata = 32'h1111_2222; ready = 1'b1;
    tick();
    chk("t5_tie_grant", {31'd0, grant}, 32'd0);
    tick(); tick(); tick();
    chk("t5_done_ack0", {31'd0, ack0}, 32'd1);
    chk("t5_done_rdata", rdata, 32'h1111_2222);
    $display("txn cpu read after reset rdata=%h err=%0d", rdata, err0);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Ready held low: exactly 255 WAIT cycles, then a timeout error.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_9010; ready = 1'b0;
    tick(); tick(); tick();
    acks_seen = 0;
    for (int i = 0; i < 254; i++) begin
      tick();
      if (ack0 || ack1) acks_seen++;
    end
    chk("t4_early_acks", acks_seen, 0);
    chk("t4_wait255_clk", {31'd0, bus_clk}, 32'd1);
    tick();
    chk("t4_done_ack0", {31'd0, ack0}, 32'd1);
    chk("t4_done_err0", {31'd0, err0}, 32'd1);
    chk("t4_done_ack1", {31'd0, ack1}, 32'd0);
    chk("t4_done_rdata", rdata, 32'h0);
    $display("txn cpu read timeout rdata=%h err=%0d", rdata, err0);
    req0 = 1'b0;
    tick();
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);

    // Ready high only during SETUP is ignored; completion waits for WAIT.
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_900C;
    bus_rdata = 32'hCAFE_F00D; ready = 1'b0;
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    chk("t6_wait1_ack1", {31'd0, ack1}, 32'd0);
    tick();
    chk("t6_wait2_ack1", {31'd0, ack1}, 32'd0);
    chk("t6_wait2_clk", {31'd0, bus_clk}, 32'd1);
    ready = 1'b1;
    tick();
    chk("t6_done_ack1", {31'd0, ack1}, 32'd1);
    chk("t6_done_err1", {31'd0, err1}, 32'd0);
    chk("t6_done_rdata", rdata, 32'hCAFE_F00D);
    $display("txn dma read addr=%h rdata=%h err=%0d", 32'h0000_900C, rdata, err1);
    req1 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
